// File: rtl/mem_access_ctrl_if.sv
// Bundle of CPU-side and RAM-side signals of the memory-access controller.
// The slave modport is the controller's view; master is the environment's view.
interface mem_access_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] bus_in;
  logic              mar_en;
  logic              mdr_en;
  logic              req_rd;
  logic              req_wr;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] mdr_out;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_wr_en;
  logic              ram_rd_en;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  bus_in, mar_en, mdr_en, req_rd, req_wr, ram_rdata,
    output busy, done, err, mdr_out, ram_addr, ram_wdata, ram_wr_en, ram_rd_en
  );

  modport master (
    output bus_in, mar_en, mdr_en, req_rd, req_wr, ram_rdata,
    input  busy, done, err, mdr_out, ram_addr, ram_wdata, ram_wr_en, ram_rd_en
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Memory-access controller: owns MAR/MDR and sequences one RAM read or write
// per req/done handshake; handshake and RAM strobes are decoded from state only.
module mem_access_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input logic               clk,
  input logic               clr,
  mem_access_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    RD_CAP   = 3'd3,
    WR_ISSUE = 3'd4,
    DONE     = 3'd5,
    ERR      = 3'd6
  } state_t;

  localparam logic [2:0] WAIT_INIT = 3'(RD_LAT - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic              addr_bad_q, addr_bad_d;
  logic [2:0]        cnt_q, cnt_d;

  // State, address/data registers and read-wait counter
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= IDLE;
      mar_q      <= {ADDR_W{1'b0}};
      mdr_q      <= {DATA_W{1'b0}};
      addr_bad_q <= 1'b0;
      cnt_q      <= 3'd0;
    end else begin
      state_q    <= state_d;
      mar_q      <= mar_d;
      mdr_q      <= mdr_d;
      addr_bad_q <= addr_bad_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state decode; loads only in IDLE, and a request on the same edge
  // sees the pre-load MAR/MDR because it reads the _q values
  always_comb begin
    state_d    = state_q;
    mar_d      = mar_q;
    mdr_d      = mdr_q;
    addr_bad_d = addr_bad_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.mar_en) begin
          mar_d      = bus.bus_in[ADDR_W-1:0];
          addr_bad_d = |bus.bus_in[DATA_W-1:ADDR_W];
        end else begin
          mar_d      = mar_q;
          addr_bad_d = addr_bad_q;
        end
        if (bus.mdr_en) begin
          mdr_d = bus.bus_in;
        end else begin
          mdr_d = mdr_q;
        end
        if (bus.req_rd && bus.req_wr) begin
          state_d = ERR;
        end else if ((bus.req_rd || bus.req_wr) && addr_bad_q) begin
          state_d = ERR;
        end else if (bus.req_rd) begin
          state_d = RD_ISSUE;
        end else if (bus.req_wr) begin
          state_d = WR_ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      RD_ISSUE: begin
        if (RD_LAT == 1) begin
          state_d = RD_CAP;
        end else begin
          state_d = RD_WAIT;
          cnt_d   = WAIT_INIT;
        end
      end
      RD_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = RD_CAP;
        end else begin
          state_d = RD_WAIT;
        end
      end
      RD_CAP: begin
        mdr_d   = bus.ram_rdata;
        state_d = DONE;
      end
      WR_ISSUE: state_d = DONE;
      DONE:     state_d = IDLE;
      ERR:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE) || (state_q == ERR);
  assign bus.err       = (state_q == ERR);
  assign bus.ram_rd_en = (state_q == RD_ISSUE);
  assign bus.ram_wr_en = (state_q == WR_ISSUE);
  assign bus.ram_addr  = mar_q;
  assign bus.ram_wdata = mdr_q;
  assign bus.mdr_out   = mdr_q;

endmodule
